// File: rtl/if_fetch_btb.sv
// Instruction fetch stage: owns the PC, drives instruction memory and predicts the
// next PC with a direct-mapped BTB of 2-bit saturating counters.

`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_NONE
`define STALL_NONE 2'd0
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 2'd1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2'd2
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module if_fetch_btb #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`STALL_WIDTH-1:0]    stall,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       upd_valid,
    input  logic [31:0]                upd_pc,
    input  logic                       upd_taken,
    input  logic [31:0]                upd_target,
    output logic [`MEM_ADDR_WIDTH-1:0] inst_addr,
    input  logic [`REG_DATA_WIDTH-1:0] inst_rdata,
    output logic [`MEM_ADDR_WIDTH-1:0] PC_if,
    output logic [`REG_DATA_WIDTH-1:0] inst_if,
    output logic                       bp_if,
    output logic [31:0]                BTB_target_if
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [31:0]       btb_target [BTB_ENTRIES];
    logic [1:0]        btb_ctr    [BTB_ENTRIES];

    logic [31:0]       pc;

    logic [IDX-1:0]    look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic              look_hit;
    logic              predict_taken;
    logic [31:0]       predict_target;

    logic [IDX-1:0]    upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    logic              stall_hold;
    logic              unused_upd_low_bits;

    assign look_idx       = pc[IDX+1:2];
    assign look_tag       = pc[31:IDX+2];
    assign look_hit       = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign predict_taken  = look_hit && btb_ctr[look_idx][1];
    assign predict_target = predict_taken ? btb_target[look_idx] : 32'h0000_0000;

    // Byte offset of the update PC never selects an entry.
    assign upd_idx             = upd_pc[IDX+1:2];
    assign upd_tag             = upd_pc[31:IDX+2];
    assign upd_hit             = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign unused_upd_low_bits = ^upd_pc[1:0];

    assign stall_hold = (stall == `STALL_LOAD) || (stall == `STALL_BRANCH);

    assign inst_addr     = pc;
    assign PC_if         = pc;
    assign inst_if       = inst_rdata;
    assign bp_if         = predict_taken;
    assign BTB_target_if = predict_target;

    // A redirect from EX beats any stall; otherwise follow the prediction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (stall_hold) begin
            pc <= pc;
        end else if (predict_taken) begin
            pc <= predict_target;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (btb_ctr[upd_idx] != 2'b11) begin
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
                    end
                end else if (btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag rewrite on a taken hit is harmless since it already matches.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_if_fetch_btb.sv
// Directed bench for if_fetch_btb: stimulus pushes expected fetch outputs into a
// queue that a separate monitor pops and compares each cycle.

`ifndef STALL_WIDTH
`define STALL_WIDTH 2
`endif
`ifndef STALL_NONE
`define STALL_NONE 2'd0
`endif
`ifndef STALL_LOAD
`define STALL_LOAD 2'd1
`endif
`ifndef STALL_BRANCH
`define STALL_BRANCH 2'd2
`endif

module tb_if_fetch_btb;

    localparam logic [31:0] MEM_XOR = 32'hDEAD_BEEF;

    logic                    clk;
    logic                    rst;
    logic [`STALL_WIDTH-1:0] stall;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    upd_valid;
    logic [31:0]             upd_pc;
    logic                    upd_taken;
    logic [31:0]             upd_target;
    logic [31:0]             inst_addr;
    logic [31:0]             inst_rdata;
    logic [31:0]             PC_if;
    logic [31:0]             inst_if;
    logic                    bp_if;
    logic [31:0]             BTB_target_if;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        bp;
        logic [31:0] tgt;
    } exp_t;

    exp_t expect_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    event sample_now;

    if_fetch_btb #(.BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .PC_if         (PC_if),
        .inst_if       (inst_if),
        .bp_if         (bp_if),
        .BTB_target_if (BTB_target_if)
    );

    // Instruction memory stand-in: a recognisable word derived from the address.
    assign inst_rdata = inst_addr ^ MEM_XOR;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_expect(input logic [31:0] e_pc, input logic e_bp, input logic [31:0] e_tgt);
        exp_t e;
        e.id  = step_id;
        e.pc  = e_pc;
        e.bp  = e_bp;
        e.tgt = e_tgt;
        expect_q.push_back(e);
        step_id++;
    endtask

    task automatic apply_stimulus(
        input logic [`STALL_WIDTH-1:0] st,
        input logic                    rv,
        input logic [31:0]             rpc,
        input logic                    uv,
        input logic [31:0]             upc,
        input logic                    ut,
        input logic [31:0]             utg,
        input logic [31:0]             e_pc,
        input logic                    e_bp,
        input logic [31:0]             e_tgt
    );
        @(posedge clk);
        #1;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utg;
        push_expect(e_pc, e_bp, e_tgt);
    endtask

    task automatic compare(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s step %0d got %h expected %h", name, id, got, want);
        end
    endtask

    task automatic check_output();
        exp_t e;
        e = expect_q.pop_front();
        compare("PC_if",         e.id, PC_if,          e.pc);
        compare("inst_addr",     e.id, inst_addr,      e.pc);
        compare("inst_if",       e.id, inst_if,        e.pc ^ MEM_XOR);
        compare("bp_if",         e.id, {31'd0, bp_if}, {31'd0, e.bp});
        compare("BTB_target_if", e.id, BTB_target_if,  e.tgt);
    endtask

    initial begin
        forever begin
            @(negedge clk or sample_now);
            if (expect_q.size() > 0) check_output();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst            = 1'b0;
        stall          = `STALL_NONE;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_target     = '0;

        // Reset state, then sequential fetch with a two-cycle load stall at 0x8.
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h00, 0, 0);
        rst = 1'b1;
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h04, 0, 0);
        apply_stimulus(`STALL_LOAD,   0, 0, 0, 0, 0, 0, 32'h08, 0, 0);
        apply_stimulus(`STALL_LOAD,   0, 0, 0, 0, 0, 0, 32'h08, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h08, 0, 0);
        // Allocate 0x10 -> 0x40, predicted taken on the very next fetch.
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 1, 32'h40, 32'h0C, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h10, 1, 32'h40);
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 0, 0, 32'h40, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h10, 0, 0, 0, 0, 32'h44, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        // Three taken updates saturate at 2'b11; one not-taken still predicts taken.
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 1, 32'h40, 32'h14, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 1, 32'h40, 32'h18, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 1, 32'h40, 32'h1C, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 0, 0, 32'h20, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h10, 0, 0, 0, 0, 32'h24, 0, 0);
        // Same-cycle update to the looked-up entry: lookup sees the old counter.
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h10, 0, 0, 32'h10, 1, 32'h40);
        apply_stimulus(`STALL_BRANCH, 1, 32'h200, 0, 0, 0, 0, 32'h40, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h200, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h10, 0, 0, 0, 0, 32'h204, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        // Aliasing: 0x50 shares index 4 with 0x10 and evicts it.
        apply_stimulus(`STALL_NONE,   0, 0, 1, 32'h50, 1, 32'h80, 32'h14, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h10, 0, 0, 0, 0, 32'h18, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h50, 0, 0, 0, 0, 32'h10, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h50, 1, 32'h80);
        // 32-bit wrap of the sequential PC.
        apply_stimulus(`STALL_NONE,   1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'h80, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h00, 0, 0);
        // Misaligned redirect is loaded as-is but indexes on bits above [1:0].
        apply_stimulus(`STALL_NONE,   1, 32'h52, 0, 0, 0, 0, 32'h04, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h52, 1, 32'h80);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h80, 0, 0);

        // Asynchronous reset mid-cycle: PC must drop before the next clock edge.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        push_expect(32'h00, 0, 0);
        ->sample_now;
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h00, 0, 0);
        rst = 1'b1;
        apply_stimulus(`STALL_NONE,   1, 32'h10, 0, 0, 0, 0, 32'h04, 0, 0);
        apply_stimulus(`STALL_NONE,   1, 32'h50, 0, 0, 0, 0, 32'h10, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h50, 0, 0);
        apply_stimulus(`STALL_NONE,   0, 0, 0, 0, 0, 0, 32'h54, 0, 0);

        for (int n = 0; n < 10 && expect_q.size() > 0; n++) @(negedge clk);
        #1;
        checks++;
        if (expect_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d expected 0", expect_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
